// File: rtl/bullet_pkg.sv
// Shared definitions for the bullet object table: geometry, OAM field layout,
// direction/state encodings and the entry packing helper.
package bullet_pkg;

    localparam int OAM_DEPTH  = 16;
    localparam int OAM_WORD_W = 32;
    localparam int IDX_W      = 4;
    localparam int COUNT_W    = 5;
    localparam int COORD_W    = 10;

    localparam int SPEED    = 2;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int TILE_W   = 8;
    localparam int TILE_H   = 8;

    // OAM entry layout; bits [31:29] are always zero.
    localparam int OAM_EN_BIT   = 28;
    localparam int OAM_X_LSB    = 18;
    localparam int OAM_Y_LSB    = 8;
    localparam int OAM_ROW_LSB  = 5;
    localparam int OAM_DIRX_LSB = 2;
    localparam int OAM_DIR_LSB  = 0;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_t;

    function automatic logic [OAM_WORD_W-1:0] pack_entry(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [2:0]         row,
        input dir_t               dir
    );
        logic [OAM_WORD_W-1:0] w;
        w                          = '0;
        w[OAM_EN_BIT]              = 1'b1;
        w[OAM_X_LSB +: COORD_W]    = x;
        w[OAM_Y_LSB +: COORD_W]    = y;
        w[OAM_ROW_LSB +: 3]        = row;
        w[OAM_DIRX_LSB +: 3]       = {1'b0, dir};
        w[OAM_DIR_LSB +: 2]        = dir;
        return w;
    endfunction

endpackage

// File: rtl/bullet_step.sv
// Next-frame value of one OAM entry: moves an enabled bullet by SPEED along
// its direction, or returns an all-zero entry when it would leave the playfield.
module bullet_step
    import bullet_pkg::*;
(
    input  logic [OAM_WORD_W-1:0] entry,
    output logic [OAM_WORD_W-1:0] next_entry
);

    localparam logic [COORD_W:0] SPEED_11   = (COORD_W+1)'(SPEED);
    localparam logic [COORD_W:0] RIGHT_LIM  = (COORD_W+1)'(SCREEN_W - TILE_W);
    localparam logic [COORD_W:0] BOTTOM_LIM = (COORD_W+1)'(SCREEN_H - TILE_H);

    logic [COORD_W:0]   x_ext;
    logic [COORD_W:0]   y_ext;
    logic [COORD_W-1:0] x_new;
    logic [COORD_W-1:0] y_new;
    logic               out_of_bounds;
    dir_t               dir;

    assign x_ext = {1'b0, entry[OAM_X_LSB +: COORD_W]};
    assign y_ext = {1'b0, entry[OAM_Y_LSB +: COORD_W]};
    assign dir   = dir_t'(entry[OAM_DIR_LSB +: 2]);

    // Bounds are checked on the 11-bit pre-move coordinate so x+SPEED cannot wrap.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any branch, so no path can infer a latch.
        x_new         = entry[OAM_X_LSB +: COORD_W];
        y_new         = entry[OAM_Y_LSB +: COORD_W];
        out_of_bounds = 1'b0;
        unique case (dir)
            DIR_UP: begin
                out_of_bounds = (y_ext < SPEED_11);
                y_new         = COORD_W'(y_ext - SPEED_11);
            end
            DIR_RIGHT: begin
                out_of_bounds = ((x_ext + SPEED_11) > RIGHT_LIM);
                x_new         = COORD_W'(x_ext + SPEED_11);
            end
            DIR_DOWN: begin
                out_of_bounds = ((y_ext + SPEED_11) > BOTTOM_LIM);
                y_new         = COORD_W'(y_ext + SPEED_11);
            end
            DIR_LEFT: begin
                out_of_bounds = (x_ext < SPEED_11);
                x_new         = COORD_W'(x_ext - SPEED_11);
            end
            default: out_of_bounds = 1'b0;
        endcase
    end

    // A disabled entry passes through untouched.
    always_comb begin
        next_entry = entry;
        if (entry[OAM_EN_BIT]) begin
            if (out_of_bounds) begin
                next_entry = '0;
            end else begin
                next_entry[OAM_X_LSB +: COORD_W] = x_new;
                next_entry[OAM_Y_LSB +: COORD_W] = y_new;
            end
        end
    end

endmodule

// File: rtl/bullet_manager.sv
// Bullet OAM owner: allocates the lowest free slot on fire, walks the table once
// per frame to move/retire bullets, and retires single slots on kill requests.
module bullet_manager
    import bullet_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 frame_tick,
    input  logic                                 fire_valid,
    output logic                                 fire_ready,
    input  logic [COORD_W-1:0]                   fire_x,
    input  logic [COORD_W-1:0]                   fire_y,
    input  logic [1:0]                           fire_dir,
    input  logic [2:0]                           fire_row,
    input  logic                                 kill_valid,
    input  logic [IDX_W-1:0]                     kill_idx,
    output logic [OAM_DEPTH-1:0][OAM_WORD_W-1:0] oam_data,
    output logic [COUNT_W-1:0]                   active_count,
    output logic                                 busy
);

    state_t                state;
    state_t                state_nx;
    logic [IDX_W-1:0]      upd_idx;
    logic [IDX_W-1:0]      upd_idx_nx;

    logic [OAM_WORD_W-1:0] oam_q [OAM_DEPTH];
    logic [OAM_WORD_W-1:0] step_next;
    logic [OAM_WORD_W-1:0] spawn_entry;
    logic [OAM_DEPTH-1:0]  en_vec;
    logic [IDX_W-1:0]      free_idx;
    logic                  any_free;
    logic                  fire_hs;

    always_comb begin
        for (int k = 0; k < OAM_DEPTH; k++) begin
            en_vec[k]   = oam_q[k][OAM_EN_BIT];
            oam_data[k] = oam_q[k];
        end
    end

    assign any_free = ~&en_vec;

    // Scanning downward lets the lowest free index overwrite higher ones.
    always_comb begin
        free_idx = '0;
        for (int k = OAM_DEPTH - 1; k >= 0; k--) begin
            if (!en_vec[k]) free_idx = IDX_W'(k);
        end
    end

    always_comb begin
        active_count = '0;
        for (int k = 0; k < OAM_DEPTH; k++) begin
            active_count = active_count + COUNT_W'(en_vec[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            upd_idx <= '0;
        end else begin
            state   <= state_nx;
            upd_idx <= upd_idx_nx;
        end
    end

    // rst_n gates fire_ready so no handshake is advertised while reset is held.
    always_comb begin
        state_nx   = state;
        upd_idx_nx = upd_idx;
        busy       = 1'b0;
        fire_ready = 1'b0;
        unique case (state)
            ST_IDLE: begin
                fire_ready = any_free && rst_n;
                if (frame_tick) begin
                    state_nx   = ST_UPDATE;
                    upd_idx_nx = '0;
                end
            end
            ST_UPDATE: begin
                busy       = 1'b1;
                upd_idx_nx = upd_idx + 1'b1;
                if (upd_idx == IDX_W'(OAM_DEPTH - 1)) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign fire_hs     = fire_valid && fire_ready;
    assign spawn_entry = pack_entry(fire_x, fire_y, fire_row, dir_t'(fire_dir));

    bullet_step u_step (
        .entry      (oam_q[upd_idx]),
        .next_entry (step_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table is a register file the display reads directly, so every entry is reset rather than left unknown.
            for (int k = 0; k < OAM_DEPTH; k++) oam_q[k] <= '0;
        end else begin
            // NOTE: non-blocking writes to the same slot resolve to the last one; the order below encodes update < kill < spawn.
            if (state == ST_UPDATE) oam_q[upd_idx]  <= step_next;
            if (kill_valid)         oam_q[kill_idx] <= '0;
            if (fire_hs)            oam_q[free_idx] <= spawn_entry;
        end
    end

endmodule

// File: tb/tb_bullet_manager.sv
// Directed and randomized checks of bullet_manager against an integer model of
// the bullet table built from the movement, allocation and priority rules.
module tb_bullet_manager;
    import bullet_pkg::*;

    logic                                 clk = 1'b0;
    logic                                 rst_n;
    logic                                 frame_tick;
    logic                                 fire_valid;
    logic                                 fire_ready;
    logic [COORD_W-1:0]                   fire_x;
    logic [COORD_W-1:0]                   fire_y;
    logic [1:0]                           fire_dir;
    logic [2:0]                           fire_row;
    logic                                 kill_valid;
    logic [IDX_W-1:0]                     kill_idx;
    logic [OAM_DEPTH-1:0][OAM_WORD_W-1:0] oam_data;
    logic [COUNT_W-1:0]                   active_count;
    logic                                 busy;

    int checks = 0;
    int errors = 0;

    int m_en  [16];
    int m_x   [16];
    int m_y   [16];
    int m_row [16];
    int m_dir [16];
    bit m_busy;
    int m_idx;

    bullet_manager dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .fire_valid   (fire_valid),
        .fire_ready   (fire_ready),
        .fire_x       (fire_x),
        .fire_y       (fire_y),
        .fire_dir     (fire_dir),
        .fire_row     (fire_row),
        .kill_valid   (kill_valid),
        .kill_idx     (kill_idx),
        .oam_data     (oam_data),
        .active_count (active_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            m_en[k] = 0; m_x[k] = 0; m_y[k] = 0; m_row[k] = 0; m_dir[k] = 0;
        end
        m_busy = 1'b0;
        m_idx  = 0;
    endtask

    task automatic model_clear(input int k);
        m_en[k] = 0; m_x[k] = 0; m_y[k] = 0; m_row[k] = 0; m_dir[k] = 0;
    endtask

    function automatic logic [511:0] model_table();
        logic [511:0] t;
        t = '0;
        for (int k = 0; k < 16; k++) begin
            if (m_en[k] != 0)
                t[k*32 +: 32] = 32'((1 << 28) + (m_x[k] << 18) + (m_y[k] << 8) +
                                    (m_row[k] << 5) + (m_dir[k] << 2) + m_dir[k]);
        end
        return t;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int k = 0; k < 16; k++) n += (m_en[k] != 0) ? 1 : 0;
        return n;
    endfunction

    function automatic int model_free();
        for (int k = 0; k < 16; k++) if (m_en[k] == 0) return k;
        return -1;
    endfunction

    task automatic model_move(input int k);
        case (m_dir[k])
            0: if (m_y[k] < SPEED) model_clear(k); else m_y[k] -= SPEED;
            1: if (m_x[k] + SPEED > SCREEN_W - TILE_W) model_clear(k); else m_x[k] += SPEED;
            2: if (m_y[k] + SPEED > SCREEN_H - TILE_H) model_clear(k); else m_y[k] += SPEED;
            default: if (m_x[k] < SPEED) model_clear(k); else m_x[k] -= SPEED;
        endcase
    endtask

    task automatic set_in(input bit fv, input int fx, input int fy, input int fd, input int fr,
                          input bit kv, input int ki, input bit ft);
        fire_valid = fv;
        fire_x     = 10'(fx);
        fire_y     = 10'(fy);
        fire_dir   = 2'(fd);
        fire_row   = 3'(fr);
        kill_valid = kv;
        kill_idx   = 4'(ki);
        frame_tick = ft;
    endtask

    task automatic idle_in();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: predict the edge from current inputs, then compare all outputs.
    task automatic cycle();
        int fs;
        bit hs;
        fs = model_free();
        hs = fire_valid && !m_busy && (fs >= 0);
        @(posedge clk);
        if (m_busy && m_en[m_idx] != 0 && !(kill_valid && int'(kill_idx) == m_idx))
            model_move(m_idx);
        if (kill_valid) model_clear(int'(kill_idx));
        if (hs) begin
            m_en[fs] = 1; m_x[fs] = int'(fire_x); m_y[fs] = int'(fire_y);
            m_row[fs] = int'(fire_row); m_dir[fs] = int'(fire_dir);
        end
        if (m_busy) begin
            if (m_idx == 15) m_busy = 1'b0;
            else m_idx++;
        end else if (frame_tick) begin
            m_busy = 1'b1;
            m_idx  = 0;
        end
        #1;
        chk("oam_data", oam_data, model_table());
        chk("active_count", active_count, model_count());
        chk("busy", busy, m_busy);
        chk("fire_ready", fire_ready, !m_busy && model_count() < 16);
    endtask

    function automatic int rand_coord(input int lim);
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 4));
            1:       return int'($urandom_range(lim - 12, lim + 3));
            default: return int'($urandom_range(0, 1023));
        endcase
    endfunction

    initial begin
        int n;
        rst_n = 1'b0;
        idle_in();
        model_reset();
        #2;
        chk("reset_oam", oam_data, '0);
        chk("reset_active_count", active_count, 0);
        chk("reset_busy", busy, 0);
        chk("reset_fire_ready", fire_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", fire_ready, 1);

        // First spawn
        set_in(1, 100, 200, 1, 2, 0, 0, 0);
        cycle();
        chk("spawn_word", oam_data[0], 32'h1190_C845);
        chk("spawn_count", active_count, 1);

        // Right-edge boundary: 631 retires, 628 -> 630 -> 632 stays, 632 retires
        set_in(0, 0, 0, 0, 0, 1, 0, 0); cycle();
        set_in(1, 631, 50, 1, 0, 0, 0, 0); cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 1); cycle();
        idle_in(); cycle();
        chk("right_631_retired", oam_data[0], '0);
        repeat (15) cycle();
        set_in(1, 628, 60, 1, 1, 0, 0, 0); cycle();
        for (int p = 0; p < 3; p++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1); cycle();
            idle_in();
            repeat (16) cycle();
            if (p == 0) chk("right_628_moves", oam_data[0][27:18], 630);
            if (p == 1) chk("right_630_moves", oam_data[0][28:18], {1'b1, 10'd632});
            if (p == 2) chk("right_632_retired", oam_data[0], '0);
        end

        // Fill the table, stall the 17th request, then reuse a killed slot
        for (int i = 0; i < 16; i++) begin
            set_in(1, 10 + i * 8, 20 + i * 4, i % 4, i % 8, 0, 0, 0);
            cycle();
        end
        chk("full_ready", fire_ready, 0);
        chk("full_count", active_count, 16);
        set_in(1, 500, 300, 2, 5, 0, 0, 0);
        repeat (3) cycle();
        set_in(1, 500, 300, 2, 5, 1, 5, 0); cycle();
        set_in(1, 500, 300, 2, 5, 0, 0, 0); cycle();
        chk("respawn_slot5_x", oam_data[5][27:18], 500);
        idle_in();

        // Empty the table, then fire and tick together
        for (int i = 0; i < 16; i++) begin
            set_in(0, 0, 0, 0, 0, 1, i, 0);
            cycle();
        end
        set_in(1, 300, 100, 0, 3, 0, 0, 1); cycle();
        idle_in();
        n = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            n++;
            cycle();
        end
        chk("busy_cycles", n, 16);
        chk("tick_fire_y", oam_data[0][17:8], 98);

        // Kill the slot being updated, with a redundant tick in the same cycle
        for (int i = 1; i <= 4; i++) begin
            set_in(1, 200 + i * 20, 200, i % 4, 0, 0, 0, 0);
            cycle();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1); cycle();
        idle_in();
        repeat (3) cycle();
        set_in(0, 0, 0, 0, 0, 1, 3, 1); cycle();
        chk("kill_during_update", oam_data[3], '0);
        idle_in();
        n = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            n++;
            cycle();
        end
        chk("busy_after_retick", n, 12);
        repeat (4) cycle();
        chk("no_extra_pass", busy, 0);

        // Asynchronous reset in the middle of a pass
        set_in(0, 0, 0, 0, 0, 0, 0, 1); cycle();
        idle_in();
        repeat (7) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midpass_reset_oam", oam_data, '0);
        chk("midpass_reset_busy", busy, 0);
        chk("midpass_reset_ready", fire_ready, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_busy", busy, 0);
        chk("release_ready", fire_ready, 1);
        chk("release_count", active_count, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 1) == 1,
                   rand_coord(SCREEN_W - TILE_W),
                   rand_coord(SCREEN_H - TILE_H),
                   int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 7)),
                   $urandom_range(0, 7) == 0,
                   int'($urandom_range(0, 15)),
                   $urandom_range(0, 19) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
